pm_mux_4to1: RTL and testbench
==============================

Name: pm_mux_4to1

Overview:
Four-input, WIDTH-bit data selector for the processor datapath. It steers one of d0..d3 to the output under a 2-bit select.
- The combinational output y is always valid.
- A registered copy y_q is also provided for pipelined consumers. It is loaded on clk when en is high.
- y_q is cleared by an asynchronous active-high reset.

Parameters:
WIDTH, 4, data width of every input and output bus.
RST_VAL, 0, value loaded into y_q on reset. Width WIDTH.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
d0  input  WIDTH  data input, selected when sel=2'b00.
d1  input  WIDTH  data input, selected when sel=2'b01.
d2  input  WIDTH  data input, selected when sel=2'b10.
d3  input  WIDTH  data input, selected when sel=2'b11.
sel  input  2  select code.
en  input  1  load enable for y_q.
y  output  WIDTH  combinational selected data.
y_q  output  WIDTH  registered selected data.
sel_oh  output  4  one-hot decode of sel; bit i is high when sel==i.

Behaviour:
Clocking and reset: one clock, reset is asynchronous and active-high. clk and rst are the only clock and reset.

Combinational path (y, sel_oh):
- y = d0/d1/d2/d3 for sel = 00/01/10/11; zero latency, purely combinational.
- y does not depend on clk, rst or en. It is valid during reset.
- sel_oh = 4'b0001/0010/0100/1000 for sel = 00/01/10/11. It is combinational and always exactly one-hot for known sel.
- If sel contains X/Z, y and sel_oh are don't-care in simulation. Synthesis must not add a latch: use a full case with a default arm equal to the sel=00 arm.

Registered path (y_q):
- rst high: y_q = RST_VAL immediately, without waiting for a clock edge. It holds while rst stays high, regardless of en and clk.
- rst deasserted, rising clk, en=1: y_q takes the value y had just before the edge.
- rst deasserted, rising clk, en=0: y_q holds.
- Latency from d/sel change to y_q: one clock edge with en=1.
- rst asserted mid-operation clears y_q at once. The first load after release happens on the first rising edge with rst low and en=1.
- rst and a clk edge together: reset wins.

General:
- No arithmetic, no internal state other than y_q.
- Widths are exact: no truncation or extension.

Decomposition:
Shared package pm_mux_pkg holds:
- select constants SEL_D0=2'd0, SEL_D1=2'd1, SEL_D2=2'd2, SEL_D3=2'd3;
- default width constant PM_MUX_W=4.

One sub-module, pm_mux_core, is natural:
- a purely combinational WIDTH-parameterised 4:1 selector with outputs y and sel_oh;
- pm_mux_4to1 instantiates it and adds the enable/reset output register.

Test Plan:
1. d0=0,d1=1,d2=2,d3=3. Step sel 00,01,10,11, 10 time units each -> y = 0,1,2,3 at each step; sel_oh = 0001,0010,0100,1000.
2. Same data, en=1, rst low, sel stepped once per clock -> y_q equals the previous cycle's y: 0,1,2,3 one edge later.
3. y_q=3, en=0, sel changed to 00 across several edges -> y follows to 0; y_q stays 3.
4. rst pulsed high between clock edges while y_q=2 -> y_q=0 immediately, before any edge. y still tracks sel: sel=11 gives y=3. After release with en=1, the next edge gives y_q=3.
5. WIDTH=8, d0=8'hA5,d1=8'h5A,d2=8'hFF,d3=8'h00, all sel codes -> y equals the selected input bit-exactly. No upper-bit loss.
6. rst held high while clk toggles with en=1 -> y_q stays RST_VAL throughout.

Source files
------------

// File: rtl/pm_mux_pkg.sv
// Shared constants for the pm_mux datapath selector.
package pm_mux_pkg;

  localparam logic [1:0] SEL_D0 = 2'd0;
  localparam logic [1:0] SEL_D1 = 2'd1;
  localparam logic [1:0] SEL_D2 = 2'd2;
  localparam logic [1:0] SEL_D3 = 2'd3;

  localparam int PM_MUX_W = 4;

endpackage

// File: rtl/pm_mux_4to1_if.sv
// Bus bundle between the datapath driver (master) and the 4:1 selector (slave).
interface pm_mux_4to1_if
  import pm_mux_pkg::*;
#(
  parameter int WIDTH = PM_MUX_W
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       sel_oh;

  modport master (
    output d0, d1, d2, d3, sel, en,
    input  y, y_q, sel_oh
  );

  modport slave (
    input  d0, d1, d2, d3, sel, en,
    output y, y_q, sel_oh
  );
endinterface

// File: rtl/pm_mux_core.sv
// Purely combinational WIDTH-bit 4:1 selector with one-hot select decode.
module pm_mux_core
  import pm_mux_pkg::*;
#(
  parameter int WIDTH = PM_MUX_W
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       sel_oh
);

  // Select data and decode sel; default arm mirrors SEL_D0 so no latch is inferred.
  always_comb begin
    y      = d0;
    sel_oh = 4'b0001;
    case (sel)
      SEL_D0: begin y = d0; sel_oh = 4'b0001; end
      SEL_D1: begin y = d1; sel_oh = 4'b0010; end
      SEL_D2: begin y = d2; sel_oh = 4'b0100; end
      SEL_D3: begin y = d3; sel_oh = 4'b1000; end
      default: begin y = d0; sel_oh = 4'b0001; end
    endcase
  end

endmodule

// File: rtl/pm_mux_4to1.sv
// 4:1 data selector with a combinational output and an enabled, async-reset registered copy.
module pm_mux_4to1
  import pm_mux_pkg::*;
#(
  parameter int               WIDTH   = PM_MUX_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  pm_mux_4to1_if.slave  bus
);

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       sel_oh;

  pm_mux_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .d0     (bus.d0),
    .d1     (bus.d1),
    .d2     (bus.d2),
    .d3     (bus.d3),
    .sel    (bus.sel),
    .y      (y),
    .sel_oh (sel_oh)
  );

  // Next register value: load the selected data when enabled, otherwise hold.
  always_comb begin
    y_d = y_q;
    if (bus.en) y_d = y;
  end

  // Output register; reset takes effect immediately and wins over a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= RST_VAL;
    else     y_q <= y_d;
  end

  assign bus.y      = y;
  assign bus.y_q    = y_q;
  assign bus.sel_oh = sel_oh;

endmodule

// File: tb/tb_pm_mux_4to1.sv
// Scoreboard bench for pm_mux_4to1: 4-bit and 8-bit instances share clk/rst/sel/en.
module tb_pm_mux_4to1;
  import pm_mux_pkg::*;

  localparam logic [3:0] RST4 = 4'h0;
  localparam logic [7:0] RST8 = 8'h3C;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       en;
  logic [3:0] d4 [4];
  logic [7:0] d8 [4];

  logic [3:0] m4;
  logic [7:0] m8;
  logic [31:0] sb_q [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pm_mux_4to1_if #(.WIDTH(4)) bus4 ();
  pm_mux_4to1_if #(.WIDTH(8)) bus8 ();

  assign bus4.d0 = d4[0];
  assign bus4.d1 = d4[1];
  assign bus4.d2 = d4[2];
  assign bus4.d3 = d4[3];
  assign bus4.sel = sel;
  assign bus4.en  = en;
  assign bus8.d0 = d8[0];
  assign bus8.d1 = d8[1];
  assign bus8.d2 = d8[2];
  assign bus8.d3 = d8[3];
  assign bus8.sel = sel;
  assign bus8.en  = en;

  pm_mux_4to1 #(.WIDTH(4), .RST_VAL(RST4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  pm_mux_4to1 #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = 'x;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    check_val(tag, obs, exp);
  endtask

  // Combinational outputs after inputs settle.
  task automatic comb_chk(input string tag);
    logic [3:0] oh;
    #1;
    oh = 4'b0001 << sel;
    check_val({tag, "_y4"},  32'(bus4.y),      32'(d4[sel]));
    check_val({tag, "_oh"},  32'(bus4.sel_oh), 32'(oh));
    check_val({tag, "_y8"},  32'(bus8.y),      32'(d8[sel]));
    check_val({tag, "_oh8"}, 32'(bus8.sel_oh), 32'(oh));
  endtask

  // Predict the register after the next rising edge, push, then compare just after it.
  task automatic tick(input string tag);
    if (rst) begin
      m4 = RST4;
      m8 = RST8;
    end else if (en) begin
      m4 = d4[sel];
      m8 = d8[sel];
    end
    sb_q.push_back(32'(m4));
    sb_q.push_back(32'(m8));
    @(posedge clk);
    #1;
    sb_pop_check({tag, "_yq4"}, 32'(bus4.y_q));
    sb_pop_check({tag, "_yq8"}, 32'(bus8.y_q));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    sel = SEL_D0;
    d4[0] = 4'd0; d4[1] = 4'd1; d4[2] = 4'd2; d4[3] = 4'd3;
    d8[0] = 8'hA5; d8[1] = 8'h5A; d8[2] = 8'hFF; d8[3] = 8'h00;

    // Reset value present before any clock edge.
    #3;
    check_val("rst_yq4", 32'(bus4.y_q), 32'(RST4));
    check_val("rst_yq8", 32'(bus8.y_q), 32'(RST8));
    @(negedge clk);

    // Select stepping with rst held and en=1: y valid, y_q pinned to reset value.
    en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      comb_chk("t1");
      check_val("t1_const", 32'(bus4.y), s);
      tick("t6_rst");
    end

    // Release and load one select per clock.
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick("t2");
    end

    // Hold with en=0 while y follows sel.
    en  = 1'b0;
    sel = SEL_D0;
    comb_chk("t3");
    repeat (3) tick("t3_hold");

    // Async reset between edges.
    en  = 1'b1;
    sel = SEL_D2;
    tick("t4_load");
    #2;
    rst = 1'b1;
    #1;
    m4 = RST4;
    m8 = RST8;
    check_val("t4_async4", 32'(bus4.y_q), 32'(m4));
    check_val("t4_async8", 32'(bus8.y_q), 32'(m8));
    sel = SEL_D3;
    comb_chk("t4_y");
    @(negedge clk);
    tick("t4_in_rst");
    rst = 1'b0;
    tick("t4_rel");

    // 8-bit patterns, every select code, registered too.
    for (int s = 3; s >= 0; s--) begin
      sel = 2'(s);
      comb_chk("t5");
      tick("t5_load");
    end

    // Random mix of data, select and enable.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        d4[i] = 4'($urandom);
        d8[i] = 8'($urandom);
      end
      sel = 2'($urandom_range(0, 3));
      en  = 1'($urandom_range(0, 1));
      comb_chk("rnd");
      tick("rnd");
    end

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
